// File: rtl/led_colour_driver_if.sv
// Colour-code link between the colour sequencer and the LED PWM driver.
// master: drives colour, observes the three LED lines and busy.
// slave : consumes colour, drives led_r/led_g/led_b and busy.
interface led_colour_driver_if;
    logic [2:0] colour;   // bit2=R, bit1=G, bit0=B
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       busy;     // some channel is still fading towards its target

    modport master (
        output colour,
        input  led_r,
        input  led_g,
        input  led_b,
        input  busy
    );

    modport slave (
        input  colour,
        output led_r,
        output led_g,
        output led_b,
        output busy
    );
endinterface

// File: rtl/led_colour_driver.sv
// Decodes a 3-bit colour code into R/G/B PWM channels that fade linearly to each new target.
// Latency: colour -> colour_q 1 cycle; duty moves by FADE_STEP per prescaler tick; led is registered.
// Backpressure: none; colour is sampled every cycle and busy only reports fades in progress.
// Ports: clk, rst (async, active-high), bus (slave modport: colour in; led_r/led_g/led_b/busy out).
module led_colour_driver #(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 4,
    parameter int FADE_STEP = 16,
    parameter int MAX_DUTY  = 255
) (
    input  logic               clk,
    input  logic               rst,
    led_colour_driver_if.slave bus
);
    // A one-bit prescaler still works for PRESCALE=1: it sits at 0 and ticks every cycle.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    // One extra bit so duty+FADE_STEP and target+FADE_STEP cannot overflow.
    localparam int AW   = PWM_BITS + 1;

    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [AW-1:0]       STEP_W   = AW'(FADE_STEP);
    localparam logic [PWM_BITS-1:0] DUTY_ON  = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);
    localparam logic [PS_W-1:0]     PS_ONE   = PS_W'(1);

    // Channel index matches the colour bit: 2=R, 1=G, 0=B.
    logic [2:0]                colour_q;
    logic [PS_W-1:0]           prescaler;
    logic                      tick;
    logic [PWM_BITS-1:0]       pwm_cnt;
    logic [2:0][PWM_BITS-1:0]  duty;
    logic [2:0][PWM_BITS-1:0]  duty_nxt;
    logic [2:0][PWM_BITS-1:0]  target;
    logic [2:0]                led_q;

    assign tick = (prescaler == PS_LAST);

    always_comb begin
        target = '0;
        for (int i = 0; i < 3; i++) begin
            target[i] = colour_q[i] ? DUTY_ON : '0;
        end
    end

    // Step each channel towards its target, clamping on the target so a
    // ramp never overshoots; a retarget mid-fade simply continues from the
    // present duty.
    always_comb begin
        logic [AW-1:0] d_w;
        logic [AW-1:0] t_w;
        d_w      = '0;
        t_w      = '0;
        duty_nxt = duty;
        for (int i = 0; i < 3; i++) begin
            d_w = {1'b0, duty[i]};
            t_w = {1'b0, target[i]};
            if (tick) begin
                if (d_w < t_w) begin
                    duty_nxt[i] = ((d_w + STEP_W) >= t_w) ? target[i]
                                                          : PWM_BITS'(d_w + STEP_W);
                end else if (d_w > t_w) begin
                    duty_nxt[i] = (d_w <= (t_w + STEP_W)) ? target[i]
                                                          : PWM_BITS'(d_w - STEP_W);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            colour_q  <= '0;
            prescaler <= '0;
            pwm_cnt   <= '0;
            duty      <= '0;
            led_q     <= '0;
        end else begin
            colour_q  <= bus.colour;
            prescaler <= tick ? '0 : (prescaler + PS_ONE);
            pwm_cnt   <= pwm_cnt + CNT_ONE;
            duty      <= duty_nxt;
            for (int i = 0; i < 3; i++) begin
                led_q[i] <= (pwm_cnt < duty[i]);
            end
        end
    end

    assign bus.led_r = led_q[2];
    assign bus.led_g = led_q[1];
    assign bus.led_b = led_q[0];

    // Registers are already cleared by rst, but gate anyway so busy is
    // guaranteed low for the whole time rst is held.
    assign bus.busy  = ~rst & (duty != target);
endmodule

// File: tb/tb_led_colour_driver.sv
// Bench for led_colour_driver: three instances (default, MAX_DUTY=128/FADE_STEP=50, PRESCALE=1)
// share one colour stimulus and are compared each cycle against an arithmetic fade model.
// Directed phases cover reset, full fades, partial fades, async reset, saturation and fast toggling.
module tb_led_colour_driver;
    logic       clk;
    logic       rst;
    logic [2:0] col;

    led_colour_driver_if if0 ();
    led_colour_driver_if if1 ();
    led_colour_driver_if if2 ();

    assign if0.colour = col;
    assign if1.colour = col;
    assign if2.colour = col;

    led_colour_driver u0 (.clk(clk), .rst(rst), .bus(if0));
    led_colour_driver #(.PWM_BITS(8), .PRESCALE(4), .FADE_STEP(50), .MAX_DUTY(128))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    led_colour_driver #(.PWM_BITS(8), .PRESCALE(1), .FADE_STEP(16), .MAX_DUTY(255))
        u2 (.clk(clk), .rst(rst), .bus(if2));

    // {busy, led_r, led_g, led_b} per instance
    logic [3:0] outs [3];
    assign outs[0] = {if0.busy, if0.led_r, if0.led_g, if0.led_b};
    assign outs[1] = {if1.busy, if1.led_r, if1.led_g, if1.led_b};
    assign outs[2] = {if2.busy, if2.led_r, if2.led_g, if2.led_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance parameters as the model sees them.
    int ps_m   [3] = '{4, 4, 1};
    int step_m [3] = '{16, 50, 16};
    int max_m  [3] = '{255, 128, 255};

    // Model state: duty per instance/channel (index 2=R,1=G,0=B), registered
    // colour, edges since reset release, predicted LED bits.
    int       md   [3][3];
    bit [2:0] mcq;
    int       n_edge;
    bit [2:0] mled [3];

    int n_chk;
    int n_pass;
    int cnt [3][3];

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            for (int c = 0; c < 3; c++) md[u][c] = 0;
            mled[u] = '0;
        end
        mcq    = '0;
        n_edge = 0;
    endtask

    // Advance the model by one clock edge, let the DUTs take the edge, then
    // compare all outputs 1 time unit later.
    task automatic step();
        for (int u = 0; u < 3; u++) begin
            bit tk;
            tk = ((n_edge % ps_m[u]) == ps_m[u] - 1);
            for (int c = 0; c < 3; c++) begin
                int tgt;
                tgt = mcq[c] ? max_m[u] : 0;
                mled[u][c] = ((n_edge % 256) < md[u][c]);
                if (tk) begin
                    if (md[u][c] < tgt)
                        md[u][c] = (md[u][c] + step_m[u] > tgt) ? tgt : md[u][c] + step_m[u];
                    else if (md[u][c] > tgt)
                        md[u][c] = (md[u][c] - step_m[u] < tgt) ? tgt : md[u][c] - step_m[u];
                end
            end
        end
        mcq = col;
        n_edge++;
        @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            bit b;
            b = 1'b0;
            for (int c = 0; c < 3; c++)
                if (md[u][c] != (mcq[c] ? max_m[u] : 0)) b = 1'b1;
            check($sformatf("out%0d@%0d", u, n_edge), int'(outs[u]), int'({b, mled[u]}));
        end
    endtask

    task automatic count_highs();
        for (int u = 0; u < 3; u++)
            for (int c = 0; c < 3; c++) cnt[u][c] = 0;
        repeat (256) begin
            step();
            for (int u = 0; u < 3; u++)
                for (int c = 0; c < 3; c++) cnt[u][c] += int'(outs[u][c]);
        end
    endtask

    // Raise rst between edges, check outputs clear without a clock edge,
    // hold for two edges, then release between edges.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) check($sformatf("%s_async%0d", tag, u), int'(outs[u]), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 3; u++) check($sformatf("%s_held%0d", tag, u), int'(outs[u]), 0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        col    = 3'b000;
        rst    = 1'b0;
        model_reset();
        #1;
        rst = 1'b1;
        #1;
        for (int u = 0; u < 3; u++) check($sformatf("reset%0d", u), int'(outs[u]), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle black for 1024 cycles.
        repeat (1024) step();

        // Full blue fade up, then steady-state PWM high counts.
        col = 3'b001;
        step();
        check("busy_rise", int'(outs[0][3]), 1);
        repeat (300) step();
        count_highs();
        check("blue255_b", cnt[0][0], 255);
        check("blue255_r", cnt[0][2], 0);
        check("blue255_g", cnt[0][1], 0);
        check("blue128_b", cnt[1][0], 128);
        check("blue_ps1_b", cnt[2][0], 255);

        // Partial fade up, then fade back down.
        col = 3'b000;
        repeat (300) step();
        col = 3'b001;
        repeat (32) step();
        col = 3'b000;
        repeat (80) step();

        // Async reset mid-fade, then white in lockstep.
        col = 3'b111;
        repeat (20) step();
        async_reset("mid");
        repeat (300) step();
        count_highs();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("white_sat%0d", c), cnt[1][c], 128);
            check($sformatf("white_full%0d", c), cnt[0][c], 255);
        end

        // Fast red toggling from black.
        col = 3'b000;
        repeat (300) step();
        repeat (20) begin
            col = col ^ 3'b100;
            step();
        end
        col = 3'b000;
        repeat (100) step();

        // Random colours with random hold times and occasional resets.
        repeat (60) begin
            col = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 90)) step();
            if ($urandom_range(0, 9) == 0) async_reset("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
